// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared IFU types and constants: cache geometry, the
//               controller-to-PLRU command struct, the controller state
//               enum, and the register macros used across the IFU.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MAFIA_DFF_MACROS_SVH
`define MAFIA_DFF_MACROS_SVH

// Plain register with synchronous active-high reset to zero.
`define MAFIA_RST_DFF(q, d, clk, rst) \
  always_ff @(posedge clk) begin \
    if (rst) q <= '0; \
    else     q <= (d); \
  end

// Enabled register with synchronous active-high reset to zero.
`define MAFIA_EN_RST_DFF(q, d, clk, en, rst) \
  always_ff @(posedge clk) begin \
    if (rst)     q <= '0; \
    else if (en) q <= (d); \
  end

`endif

package ifu_pkg;

  // Cache geometry: 16-byte lines, 16-way fully associative.
  localparam int ADDR_WIDTH   = 32;
  localparam int OFFSET_WIDTH = 4;
  localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int WAYS_NUM     = 16;
  localparam int WAY_WIDTH    = $clog2(WAYS_NUM);

  // Command from the cache controller to the PLRU replacement block.
  typedef struct packed {
    logic                 update_tree;
    logic                 cache_miss;
    logic [WAY_WIDTH-1:0] hit_cl;
  } t_cache_ctrl_plru;

  // Cache controller states.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_MISS_REQ  = 2'd2,
    S_MISS_WAIT = 2'd3
  } t_ifu_ctrl_state;

endpackage

`default_nettype wire

// File: rtl/ifu_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_cache_ctrl_if
// Description : Bundle of fetch, memory, data-array and PLRU signals seen by
//               the IFU cache controller. master = controller side,
//               slave = the surrounding fetch/memory/PLRU logic.
// Revision    : 1.0 - initial release
// ============================================================================

interface ifu_cache_ctrl_if;
  import ifu_pkg::*;

  // Fetch front-end
  logic                  fetch_req_valid;
  logic [ADDR_WIDTH-1:0] fetch_req_addr;
  logic                  fetch_req_ready;
  logic                  fetch_rsp_valid;
  logic                  fetch_rsp_hit;
  logic [WAY_WIDTH-1:0]  fetch_rsp_way;
  logic                  flush;

  // Memory line read
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;

  // Data array write port
  logic                  data_wr_en;
  logic [WAY_WIDTH-1:0]  data_wr_way;

  // PLRU replacement block
  t_cache_ctrl_plru      cache_ctrl_plru;
  logic [WAY_WIDTH-1:0]  evicted_cl;

  modport master (
    input  fetch_req_valid,
    input  fetch_req_addr,
    output fetch_req_ready,
    output fetch_rsp_valid,
    output fetch_rsp_hit,
    output fetch_rsp_way,
    input  flush,
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    output data_wr_en,
    output data_wr_way,
    output cache_ctrl_plru,
    input  evicted_cl
  );

  modport slave (
    output fetch_req_valid,
    output fetch_req_addr,
    input  fetch_req_ready,
    input  fetch_rsp_valid,
    input  fetch_rsp_hit,
    input  fetch_rsp_way,
    output flush,
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    input  data_wr_en,
    input  data_wr_way,
    input  cache_ctrl_plru,
    output evicted_cl
  );

endinterface

`default_nettype wire

// File: rtl/ifu_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : ifu_tag_array
// Description : 16-way fully-associative tag store with per-way valid bits
//               and a combinational match / priority encoder. Flush clears
//               all valid bits; a fill writes one tag and sets its valid.
// Revision    : 1.0 - initial release
// ============================================================================

module ifu_tag_array
  import ifu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [WAY_WIDTH-1:0] wr_way,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 hit,
  output logic [WAY_WIDTH-1:0] hit_way
);

  logic [WAYS_NUM-1:0]                r_valid;
  logic [WAYS_NUM-1:0]                w_valid_nxt;
  logic [WAYS_NUM-1:0][TAG_WIDTH-1:0] r_tags;
  logic [WAYS_NUM-1:0][TAG_WIDTH-1:0] w_tags_nxt;
  logic [WAYS_NUM-1:0]                w_match;

  // Next contents: flush wipes every valid bit, a fill installs one way.
  always_comb begin
    w_valid_nxt = r_valid;
    w_tags_nxt  = r_tags;
    if (flush) begin
      w_valid_nxt = '0;
    end else if (wr_en) begin
      w_valid_nxt[wr_way] = 1'b1;
      w_tags_nxt[wr_way]  = wr_tag;
    end
  end

  // Valid bits register.
  `MAFIA_RST_DFF(r_valid, w_valid_nxt, clk, rst)

  // Tag storage register.
  `MAFIA_RST_DFF(r_tags, w_tags_nxt, clk, rst)

  generate
    for (genvar gi = 0; gi < WAYS_NUM; gi++) begin : g_match
      assign w_match[gi] = r_valid[gi] && (r_tags[gi] == lookup_tag);
    end
  endgenerate

  // Priority encode the match vector; scanning downward leaves the lowest way.
  always_comb begin
    hit     = |w_match;
    hit_way = '0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit_way = WAY_WIDTH'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_cache_ctrl
// Description : IFU instruction-cache controller. Accepts fetch lookups,
//               matches against the 16-way tag array, commands the PLRU
//               block, and on a miss reads the line from memory and fills
//               the PLRU-selected victim way.
// Revision    : 1.0 - initial release
// ============================================================================

module ifu_cache_ctrl
  import ifu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ifu_cache_ctrl_if.master bus
);

  t_ifu_ctrl_state       r_state;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [WAY_WIDTH-1:0]  r_victim;

  logic                  w_idle;
  logic                  w_lookup;
  logic                  w_miss_req;
  logic                  w_miss_wait;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_miss;
  logic                  w_fill;
  logic                  w_tag_hit;
  logic [WAY_WIDTH-1:0]  w_hit_way;
  logic [TAG_WIDTH-1:0]  w_req_tag;
  t_cache_ctrl_plru      w_plru;
  logic                  w_unused_offset;

  assign w_idle      = (r_state == S_IDLE);
  assign w_lookup    = (r_state == S_LOOKUP);
  assign w_miss_req  = (r_state == S_MISS_REQ);
  assign w_miss_wait = (r_state == S_MISS_WAIT);

  // Flush only acts in IDLE and blocks acceptance on that edge.
  assign w_flush  = w_idle && bus.flush;
  assign w_accept = w_idle && !bus.flush && bus.fetch_req_valid;
  assign w_miss   = w_lookup && !w_tag_hit;
  // A response is only meaningful once the request has been accepted.
  assign w_fill   = w_miss_wait && bus.mem_rsp_valid;

  assign w_req_tag       = bus.fetch_req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign w_unused_offset = ^bus.fetch_req_addr[OFFSET_WIDTH-1:0];

  // Controller state sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (w_accept)          r_state <= S_LOOKUP;
        S_LOOKUP:    r_state <= w_tag_hit ? S_IDLE : S_MISS_REQ;
        S_MISS_REQ:  if (bus.mem_req_ready) r_state <= S_MISS_WAIT;
        S_MISS_WAIT: if (bus.mem_rsp_valid) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Latch the line tag of the accepted request.
  `MAFIA_EN_RST_DFF(r_tag, w_req_tag, clk, w_accept, rst)

  // Victim is captured once in LOOKUP and never recomputed.
  `MAFIA_EN_RST_DFF(r_victim, bus.evicted_cl, clk, w_miss, rst)

  ifu_tag_array u_tag_array (
    .clk        (clk),
    .rst        (rst),
    .flush      (w_flush),
    .wr_en      (w_fill),
    .wr_way     (r_victim),
    .wr_tag     (r_tag),
    .lookup_tag (r_tag),
    .hit        (w_tag_hit),
    .hit_way    (w_hit_way)
  );

  // PLRU command: one update pulse per lookup, zero everywhere else.
  always_comb begin
    w_plru = '0;
    if (w_lookup) begin
      w_plru.update_tree = 1'b1;
      w_plru.cache_miss  = !w_tag_hit;
      w_plru.hit_cl      = w_tag_hit ? w_hit_way : '0;
    end
  end

  // Output decode from the current state; idle outputs stay at zero.
  always_comb begin
    bus.fetch_req_ready = w_idle && !bus.flush;
    bus.fetch_rsp_valid = (w_lookup && w_tag_hit) || w_fill;
    bus.fetch_rsp_hit   = w_lookup && w_tag_hit;
    bus.fetch_rsp_way   = '0;
    if (w_lookup && w_tag_hit) begin
      bus.fetch_rsp_way = w_hit_way;
    end else if (w_fill) begin
      bus.fetch_rsp_way = r_victim;
    end
    bus.mem_req_valid   = w_miss_req;
    bus.mem_req_addr    = w_miss_req ? {r_tag, {OFFSET_WIDTH{1'b0}}} : '0;
    bus.data_wr_en      = w_fill;
    bus.data_wr_way     = w_fill ? r_victim : '0;
    bus.cache_ctrl_plru = w_plru;
  end

endmodule

`default_nettype wire
